acc_core_fsm: RTL
=================

Name: acc_core_fsm

Overview:
- Parametrised successor of the single-cycle 8-bit accumulator processor.
- Multi-cycle FETCH/EXEC core with a handshaked external instruction-memory port, configurable data width and register count, zero flag, conditional jumps and HALT.
- Sits at the top of the lab design, in place of the fixed PC/ROM/ID/RF/ALU composition; the ROM moves outside the core.

Parameters:
- DATA_W, 8, accumulator, register and immediate width (>=4).
- REG_CNT, 8, register-file entries (power of two, >=2); RA_W = clog2(REG_CNT).
- PC_W, 8, program-counter width (PC_W <= DATA_W).
- Derived: INSTR_W = 4 + RA_W + DATA_W. Encoding, MSB to LSB: opcode[3:0] | ra[RA_W-1:0] | arg[DATA_W-1:0].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_data  in  INSTR_W  instruction word.
- imem_valid  in  1  imem_data valid this cycle.
- dbg_addr  in  RA_W  debug read address.
- dbg_data  out  DATA_W  R[dbg_addr], combinational.
- acc  out  DATA_W  accumulator.
- cy  out  1  carry/borrow flag.
- zero  out  1  acc == 0, combinational from acc.
- halted  out  1  core in HALT state.

Behaviour:
- Reset (rst_n=0 at a rising edge): pc=0, acc=0, cy=0, all R[i]=0, ir=0, state=FETCH. imem_req reads 0 while rst_n=0, even in FETCH. halted=0. Reset overrides any in-flight fetch; a valid arriving in the reset cycle is ignored.
- Out of reset, FETCH: imem_req=1, imem_addr=pc. On a cycle with imem_valid=1: ir<=imem_data, go to EXEC. Otherwise stay in FETCH, waits unbounded. imem_valid outside FETCH is ignored.
- EXEC (one cycle, imem_req=0): execute ir, update state, go to FETCH. With zero-wait memory (valid in the same cycle as req) throughput is 2 cycles per instruction.
- Default pc update: pc<=pc+1, mod 2^PC_W (pc wraps from max to 0).
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc=arg.
  - 2 LD: acc=R[ra].
  - 3 ST: R[ra]=acc.
  - 4 ADD: {cy,acc}=acc+R[ra].
  - 5 ADDI: {cy,acc}=acc+arg.
  - 6 SUB: acc=acc-R[ra], cy=1 iff borrow (acc<R[ra] unsigned).
  - 7 AND, 8 OR, 9 XOR with R[ra]; cy unchanged.
  - A JMP: pc=arg[PC_W-1:0].
  - B JC: jump if cy=1.
  - C JZ: jump if acc==0, evaluated on acc before EXEC.
  - D HALT.
  - E, F: see Optional Feature.
- cy changes only on ADD/ADDI/SUB. Arithmetic is DATA_W bits with wrap-around.
- Register file: REG_CNT x DATA_W, single write port (ST in EXEC), reads combinational. dbg_data reflects a ST one cycle after the EXEC edge.
- HALT: state=HALT, halted=1, pc not incremented, imem_req=0. HALT is exited only by reset.

Optional Feature:
- Macro ACC_CORE_CALL_EN.
- Defined: adds a PC_W link register (reset 0).
  - E CALL: link=pc+1 (wrapped), pc=arg[PC_W-1:0].
  - F RET: pc=link.
  - One level deep only; a nested CALL overwrites link.
- Undefined: E and F execute as NOP (pc+1), no link register is synthesised.

Test Plan:
- Zero-wait memory; program LDI 0x05, ADDI 0xFD, HALT -> acc=0x02, cy=1. halted=1 after 6 cycles. imem_addr sequence 0,1,2.
- imem_valid delayed 3 cycles on each fetch; program LDI 0x10, ST r3, LD r0 -> dbg_addr=3 gives 0x10. Final acc=0x00, zero=1. Exactly one fetch per pc.
- acc=0x03, R1=0x05, SUB r1, then JC 0x20 -> acc=0xFE, cy=1, next imem_addr=0x20. Same sequence with R1=0x01 -> acc=0x02, cy=0, next imem_addr=pc+1.
- JMP 0xFF, then NOP at 0xFF -> following fetch address 0x00 (wrap).
- Assert rst_n=0 for one cycle during a FETCH wait, with imem_valid=1 in the same cycle -> instruction discarded, pc=0, acc=0, imem_req=0 that cycle and 1 the next.
- ACC_CORE_CALL_EN defined: CALL 0x40 at pc 0x07, RET at 0x40 -> fetches 0x40, then 0x08. Undefined: CALL at 0x07 -> next fetch 0x08.

Source files
------------

// File: rtl/acc_core_fsm.sv
// acc_core_fsm: multi-cycle FETCH/EXEC accumulator core with a handshaked instruction-memory port
// Ports: clk, rst_n (synchronous, active-low); imem_req/imem_addr out and imem_data/imem_valid in
//   form the fetch handshake; dbg_addr in / dbg_data out give a combinational register read;
//   acc, cy, zero and halted report core status.
// Optional feature: define ACC_CORE_CALL_EN to add CALL (0xE) / RET (0xF) with a one-level link register.
module acc_core_fsm #(
  parameter int DATA_W = 8,
  parameter int REG_CNT = 8,
  parameter int PC_W = 8,
  parameter int RA_W = $clog2(REG_CNT),
  parameter int INSTR_W = 4 + RA_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_valid,
  input  logic [RA_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [DATA_W-1:0]  acc,
  output logic               cy,
  output logic               zero,
  output logic               halted
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t state;
  logic [PC_W-1:0] pc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0] regs [REG_CNT];
  logic [3:0] op;
  logic [RA_W-1:0] ra;
  logic [DATA_W-1:0] arg, rv;
  logic [DATA_W:0] add_r, add_i, sub_r;
`ifdef ACC_CORE_CALL_EN
  logic [PC_W-1:0] link;
`endif
  assign op = ir[INSTR_W-1 -: 4];
  assign ra = ir[DATA_W +: RA_W];
  assign arg = ir[DATA_W-1:0];
  assign rv = regs[ra];
  // one extra bit holds the carry out of an add, or the borrow of a subtract
  assign add_r = {1'b0, acc} + {1'b0, rv};
  assign add_i = {1'b0, acc} + {1'b0, arg};
  assign sub_r = {1'b0, acc} - {1'b0, rv};
  // gated by rst_n so no request is seen while reset is being applied
  assign imem_req = rst_n && state == FETCH;
  assign imem_addr = pc;
  assign dbg_data = regs[dbg_addr];
  assign zero = acc == '0;
  assign halted = state == HALT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
      acc <= '0;
      cy <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
`ifdef ACC_CORE_CALL_EN
      link <= '0;
`endif
    end else begin
      case (state)
        FETCH: if (imem_valid) begin
          ir <= imem_data;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          pc <= pc + PC_W'(1);
          case (op)
            4'h1: acc <= arg;
            4'h2: acc <= rv;
            4'h3: regs[ra] <= acc;
            4'h4: {cy, acc} <= add_r;
            4'h5: {cy, acc} <= add_i;
            4'h6: {cy, acc} <= sub_r;
            4'h7: acc <= acc & rv;
            4'h8: acc <= acc | rv;
            4'h9: acc <= acc ^ rv;
            4'hA: pc <= arg[PC_W-1:0];
            4'hB: if (cy) pc <= arg[PC_W-1:0];
            4'hC: if (zero) pc <= arg[PC_W-1:0];
            4'hD: begin
              state <= HALT;
              pc <= pc;
            end
`ifdef ACC_CORE_CALL_EN
            4'hE: begin
              link <= pc + PC_W'(1);
              pc <= arg[PC_W-1:0];
            end
            4'hF: pc <= link;
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule
